// File: rtl/ysyx_25040111_trap_ctrl_pkg.sv
// Shared definitions for the trap sequencer: widths, CSR addresses, FSM states, op decode.
// MSTATUS helpers are only exercised when YSYX_25040111_TRAP_MSTATUS_EN is defined.
package ysyx_25040111_trap_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int CSR_AW = 12;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_EPC,
        S_W_CAUSE,
        S_W_STAT,
        S_R_VEC,
        S_R_EPC,
        S_REDIR,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_TRAP,
        OP_MRET,
        OP_EBREAK
    } op_t;

    // EBREAK outranks a trap request, which outranks MRET.
    function automatic op_t decode_op(input logic ebreak, input logic err, input logic mret);
        if (ebreak)    return OP_EBREAK;
        else if (err)  return OP_TRAP;
        else if (mret) return OP_MRET;
        else           return OP_NONE;
    endfunction

    function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r                             = s;
        r[MSTATUS_MPIE]               = s[MSTATUS_MIE];
        r[MSTATUS_MIE]                = 1'b0;
        r[MSTATUS_MPP+1:MSTATUS_MPP]  = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r               = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/ysyx_25040111_trap_ctrl_if.sv
// Bundle of the decoder input, shared CSR port, IFU redirect and status lines.
// master = trap controller, slave = surrounding core / environment.
interface ysyx_25040111_trap_ctrl_if;
    import ysyx_25040111_trap_ctrl_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic              in_err;
    logic [3:0]        in_err_type;
    logic              in_mret;
    logic              in_ebreak;

    logic              csr_wen;
    logic [CSR_AW-1:0] csr_waddr;
    logic [XLEN-1:0]   csr_wdata;
    logic [CSR_AW-1:0] csr_raddr;
    logic [XLEN-1:0]   csr_rdata;

    logic              redir_valid;
    logic              redir_ready;
    logic [XLEN-1:0]   redir_pc;

    logic              busy;
    logic              halt;

    modport master (
        input  in_valid, in_pc, in_err, in_err_type, in_mret, in_ebreak,
        output in_ready,
        output csr_wen, csr_waddr, csr_wdata, csr_raddr,
        input  csr_rdata,
        output redir_valid, redir_pc,
        input  redir_ready,
        output busy, halt
    );

    modport slave (
        output in_valid, in_pc, in_err, in_err_type, in_mret, in_ebreak,
        input  in_ready,
        input  csr_wen, csr_waddr, csr_wdata, csr_raddr,
        output csr_rdata,
        input  redir_valid, redir_pc,
        output redir_ready,
        input  busy, halt
    );

endinterface

// File: rtl/ysyx_25040111_trap_ctrl.sv
// Trap sequencer: drives the shared CSR port for ECALL/MRET, redirects the IFU, halts on EBREAK.
// Defining YSYX_25040111_TRAP_MSTATUS_EN adds the MSTATUS read-modify-write state W_STAT.
module ysyx_25040111_trap_ctrl
    import ysyx_25040111_trap_ctrl_pkg::*;
(
    input  logic                           clock,
    input  logic                           reset,
    ysyx_25040111_trap_ctrl_if.master      bus
);

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_q, redir_q, redir_nxt;
    logic [3:0]      cause_q;
    logic            accept;
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
    logic            mret_q;
`endif

    assign accept = bus.in_valid && (state == S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            redir_q <= '0;
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
            mret_q  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            redir_q <= redir_nxt;
            if (accept) begin
                pc_q    <= bus.in_pc;
                cause_q <= bus.in_err_type;
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
                mret_q  <= (decode_op(bus.in_ebreak, bus.in_err, bus.in_mret) == OP_MRET);
`endif
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        redir_nxt     = redir_q;
        bus.csr_wen   = 1'b0;
        bus.csr_waddr = '0;
        bus.csr_wdata = '0;
        bus.csr_raddr = '0;

        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    case (decode_op(bus.in_ebreak, bus.in_err, bus.in_mret))
                        OP_EBREAK: state_nxt = S_HALT;
                        OP_TRAP:   state_nxt = S_W_EPC;
                        OP_MRET:   state_nxt = S_R_EPC;
                        default:   state_nxt = S_IDLE;
                    endcase
                end
            end
            S_W_EPC: begin
                bus.csr_wen   = 1'b1;
                bus.csr_waddr = CSR_MEPC;
                bus.csr_wdata = pc_q;
                state_nxt     = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                bus.csr_wen   = 1'b1;
                bus.csr_waddr = CSR_MCAUSE;
                bus.csr_wdata = {{(XLEN-4){1'b0}}, cause_q};
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
                state_nxt     = S_W_STAT;
`else
                state_nxt     = S_R_VEC;
`endif
            end
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
            // Single port: MRET reads MEPC first, then revisits here for its MSTATUS update.
            S_W_STAT: begin
                bus.csr_raddr = CSR_MSTATUS;
                bus.csr_wen   = 1'b1;
                bus.csr_waddr = CSR_MSTATUS;
                bus.csr_wdata = mret_q ? mstatus_on_mret(bus.csr_rdata)
                                       : mstatus_on_trap(bus.csr_rdata);
                state_nxt     = mret_q ? S_REDIR : S_R_VEC;
            end
`endif
            S_R_VEC: begin
                bus.csr_raddr = CSR_MTVEC;
                redir_nxt     = bus.csr_rdata & ~32'h3;
                state_nxt     = S_REDIR;
            end
            S_R_EPC: begin
                bus.csr_raddr = CSR_MEPC;
                redir_nxt     = bus.csr_rdata;
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
                state_nxt     = S_W_STAT;
`else
                state_nxt     = S_REDIR;
`endif
            end
            S_REDIR: begin
                if (bus.redir_ready) state_nxt = S_IDLE;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.in_ready    = (state == S_IDLE);
    assign bus.busy        = (state != S_IDLE);
    assign bus.halt        = (state == S_HALT);
    assign bus.redir_valid = (state == S_REDIR);
    assign bus.redir_pc    = redir_q;

endmodule

// File: tb/tb_ysyx_25040111_trap_ctrl.sv
// Scoreboard bench for the trap sequencer: a CSR-file model answers reads, a reference model
// predicts CSR writes and redirects, and a monitor compares them as the DUT presents them.
module tb_ysyx_25040111_trap_ctrl;
    import ysyx_25040111_trap_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ysyx_25040111_trap_ctrl_if bus();

    ysyx_25040111_trap_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

`ifdef YSYX_25040111_TRAP_MSTATUS_EN
    localparam int TRAP_LAT = 5;
    localparam int MRET_LAT = 3;
`else
    localparam int TRAP_LAT = 4;
    localparam int MRET_LAT = 2;
`endif

    typedef struct {
        bit          is_redir;
        logic [11:0] addr;
        logic [31:0] data;
        int          acc;
        int          base;
        bit          seen;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          rdy_mode = 1;
    bit          mon_have;

    logic [31:0] csr_mem [0:4095];
    logic        tb_wr;
    logic [11:0] tb_waddr;
    logic [31:0] tb_wdata;

    logic [31:0] m_mepc, m_mtvec, m_mstatus;

    always @(posedge clock) cyc <= cyc + 1;

    assign bus.csr_rdata = csr_mem[bus.csr_raddr];
    always @(posedge clock) begin
        if (bus.csr_wen) csr_mem[bus.csr_waddr] <= bus.csr_wdata;
        if (tb_wr)       csr_mem[tb_waddr]      <= tb_wdata;
    end

    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0:       bus.redir_ready = ($urandom_range(0, 3) != 0);
            2:       bus.redir_ready = 1'b0;
            default: bus.redir_ready = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a CSR write or a redirect.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (bus.csr_wen) begin
                mon_have = (exp_q.size() > 0) && !exp_q[0].is_redir;
                check("csr_write_expected", 32'(mon_have), 32'd1);
                if (mon_have) begin
                    check("csr_waddr", 32'(bus.csr_waddr), 32'(exp_q[0].addr));
                    check("csr_wdata", bus.csr_wdata, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
            if (bus.redir_valid) begin
                mon_have = (exp_q.size() > 0) && exp_q[0].is_redir;
                check("redir_expected", 32'(mon_have), 32'd1);
                if (mon_have) begin
                    if (!exp_q[0].seen) begin
                        check("redir_latency", 32'(cyc), 32'(exp_q[0].acc + exp_q[0].base - 1));
                        exp_q[0].seen = 1'b1;
                    end
                    check("redir_pc", bus.redir_pc, exp_q[0].data);
                    if (bus.redir_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic push_wr(input logic [11:0] addr, input logic [31:0] data);
        exp_t e;
        e = '{is_redir: 1'b0, addr: addr, data: data, acc: 0, base: 0, seen: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic push_redir(input logic [31:0] pc, input int acc, input int base);
        exp_t e;
        e = '{is_redir: 1'b1, addr: 12'h0, data: pc, acc: acc, base: base, seen: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(bus.in_ready === 1'b1 && exp_q.size() == 0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("idle_within_budget", 32'(n < 100), 32'd1);
    endtask

    task automatic set_csr(input logic [11:0] addr, input logic [31:0] val);
        @(negedge clock);
        tb_wr = 1'b1; tb_waddr = addr; tb_wdata = val;
        @(negedge clock);
        tb_wr = 1'b0;
    endtask

    // Issues one op at the first idle cycle and records what the architecture says must follow.
    task automatic issue(input logic [31:0] pc, input logic err, input logic [3:0] typ,
                         input logic mret, input logic ebreak);
        int acc;
        @(negedge clock);
        wait_idle();
        bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_err = err;
        bus.in_err_type = typ; bus.in_mret = mret; bus.in_ebreak = ebreak;
        acc = cyc + 1;
        if (ebreak) begin
            // halts; nothing further on the CSR port or the redirect channel
        end else if (err) begin
            push_wr(CSR_MEPC, pc);
            push_wr(CSR_MCAUSE, {28'h0, typ});
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
            m_mstatus[7] = m_mstatus[3];
            m_mstatus[3] = 1'b0;
            m_mstatus[12:11] = 2'b11;
            push_wr(CSR_MSTATUS, m_mstatus);
`endif
            push_redir(m_mtvec & ~32'h3, acc, TRAP_LAT);
            m_mepc = pc;
        end else if (mret) begin
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
            m_mstatus[3] = m_mstatus[7];
            m_mstatus[7] = 1'b1;
            push_wr(CSR_MSTATUS, m_mstatus);
`endif
            push_redir(m_mepc, acc, MRET_LAT);
        end
        @(negedge clock);
        bus.in_valid = 1'b0; bus.in_err = 1'b0; bus.in_mret = 1'b0; bus.in_ebreak = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k, n;
        logic [31:0] pc, saved_ms;

        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_err = 1'b0; bus.in_err_type = '0;
        bus.in_mret = 1'b0; bus.in_ebreak = 1'b0;
        tb_wr = 1'b0; tb_waddr = '0; tb_wdata = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);

        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_halt", 32'(bus.halt), 32'd0);
        check("rst_redir_valid", 32'(bus.redir_valid), 32'd0);
        check("rst_redir_pc", bus.redir_pc, 32'd0);
        check("rst_csr_wen", 32'(bus.csr_wen), 32'd0);
        check("rst_csr_raddr", 32'(bus.csr_raddr), 32'd0);
        reset = 1'b0;

        m_mtvec = 32'h8000_0103; set_csr(CSR_MTVEC, m_mtvec);
        m_mepc  = 32'h0;         set_csr(CSR_MEPC, m_mepc);
        m_mstatus = 32'h0000_0008; set_csr(CSR_MSTATUS, m_mstatus);

        // ECALL: MEPC, MCAUSE=11, redirect to aligned MTVEC
        issue(32'h8000_0010, 1'b1, 4'd11, 1'b0, 1'b0);
        wait_idle();
        check("ecall_mepc_mem", csr_mem[CSR_MEPC], 32'h8000_0010);
        check("ecall_mcause_mem", csr_mem[CSR_MCAUSE], 32'h0000_000B);
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
        check("ecall_mstatus_mem", csr_mem[CSR_MSTATUS], 32'h0000_1880);
`endif

        // MRET to a freshly written MEPC
        m_mepc = 32'h8000_0014; set_csr(CSR_MEPC, m_mepc);
        issue(32'h8000_0100, 1'b0, 4'd0, 1'b1, 1'b0);
        wait_idle();
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
        check("mret_mstatus_mem", csr_mem[CSR_MSTATUS], 32'h0000_1888);
`endif

        // Redirect stalled by the IFU for three cycles
        rdy_mode = 2;
        issue(32'h8000_0020, 1'b1, 4'd11, 1'b0, 1'b0);
        n = 0;
        while (bus.redir_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        check("stall_redir_seen", 32'(n < 20), 32'd1);
        repeat (3) begin
            @(negedge clock);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_redir_valid", 32'(bus.redir_valid), 32'd1);
        end
        rdy_mode = 1;
        wait_idle();

        // Randomised mix of traps, MRETs, empty ops and vector changes
        rdy_mode = 0;
        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 9);
            pc = $urandom() & ~32'h3;
            if (k <= 4) begin
                issue(pc, 1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
            end else if (k <= 7) begin
                issue(pc, 1'b0, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
            end else if (k == 8) begin
                issue(pc, 1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
                check("drop_stays_idle", 32'(bus.busy), 32'd0);
            end else begin
                wait_idle();
                m_mtvec = $urandom();
                set_csr(CSR_MTVEC, m_mtvec);
            end
        end
        rdy_mode = 1;
        wait_idle();

        // Reset while MCAUSE is being written: sequence abandoned, MEPC already updated
        saved_ms = m_mstatus;
        issue(32'h8000_0040, 1'b1, 4'd11, 1'b0, 1'b0);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_redir_valid", 32'(bus.redir_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        exp_q.delete();
        m_mstatus = saved_ms;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_mepc_mem", csr_mem[CSR_MEPC], 32'h8000_0040);

        // EBREAK (with err and mret also raised) halts until reset
        issue(32'h8000_0080, 1'b1, 4'd11, 1'b1, 1'b1);
        check("halt_set", 32'(bus.halt), 32'd1);
        repeat (20) begin
            @(negedge clock);
            check("halt_in_ready", 32'(bus.in_ready), 32'd0);
            check("halt_sticky", 32'(bus.halt), 32'd1);
        end
        reset = 1'b1;
        #1;
        check("halt_cleared", 32'(bus.halt), 32'd0);
        check("halt_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        reset = 1'b0;

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
